// File: rtl/result_reader_pkg.sv
// Shared definitions for the result read-back / display path.
// Holds the FSM state encoding, the active-low 7-segment code table and the
// result-area layout defaults also used by the coprocessor write-back.
package result_reader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_WAIT    = 3'd1,
        ST_CAPTURE = 3'd2,
        ST_CONVERT = 3'd3,
        ST_SHOW    = 3'd4
    } state_e;

    // Result matrix location in the shared MemoryBlock.
    localparam int unsigned DEF_BASE_ADDR = 25;
    localparam int unsigned DEF_NUM_ELEM  = 25;

    // Active-low segments, bit order {g,f,e,d,c,b,a}.
    localparam logic [6:0] SEG_DIGIT [10] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000, 7'b0011001,
        7'b0010010, 7'b0000010, 7'b1111000, 7'b0000000, 7'b0010000
    };
    localparam logic [6:0] SEG_MINUS = 7'b0111111;
    localparam logic [6:0] SEG_BLANK = 7'b1111111;

    // Non-decimal nibbles blank the display rather than show garbage.
    function automatic logic [6:0] seg_of(input logic [3:0] d);
        logic [6:0] seg;
        seg = SEG_BLANK;
        if (d <= 4'd9) begin
            seg = SEG_DIGIT[d];
        end
        return seg;
    endfunction

endpackage

// File: rtl/bcd_dabble8.sv
// Sequential double-dabble: 8-bit unsigned binary to three BCD digits.
// Latency: start sampled on edge N, done pulses for one cycle after edge N+8.
// Ports: clk, reset (sync, active-high), start, bin in; busy, done, hundreds/tens/units out.
// A start while busy reloads and abandons the conversion in progress.
module bcd_dabble8 (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic [7:0] bin,
    output logic       busy,
    output logic       done,
    output logic [3:0] hundreds,
    output logic [3:0] tens,
    output logic [3:0] units
);

    // {hundreds, tens, units, binary} shifted left as one register.
    logic [19:0] sr_q;
    logic [19:0] sr_adj;
    logic [2:0]  cnt_q;
    logic        busy_q;
    logic        done_q;

    // Add 3 to any BCD nibble >= 5 before each shift.
    always_comb begin
        sr_adj = sr_q;
        if (sr_q[11:8]  >= 4'd5) sr_adj[11:8]  = sr_q[11:8]  + 4'd3;
        if (sr_q[15:12] >= 4'd5) sr_adj[15:12] = sr_q[15:12] + 4'd3;
        if (sr_q[19:16] >= 4'd5) sr_adj[19:16] = sr_q[19:16] + 4'd3;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sr_q   <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (start) begin
                sr_q   <= {12'b0, bin};
                cnt_q  <= '0;
                busy_q <= 1'b1;
            end else if (busy_q) begin
                sr_q  <= {sr_adj[18:0], 1'b0};
                cnt_q <= cnt_q + 3'd1;
                if (cnt_q == 3'd7) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign hundreds = sr_q[19:16];
    assign tens     = sr_q[15:12];
    assign units    = sr_q[11:8];

endmodule

// File: rtl/result_reader.sv
// Reads the 5x5 result matrix back from MemoryBlock and shows one signed element on 7-seg displays.
// Latency: valid rises READ_LAT+10 cycles after a start/step is accepted; outputs then hold in SHOW.
// Ports: clk, reset, start, step, mem_q in; mem_addr, busy, valid, elem_index, elem_value, hex0..2, hex_sign out.
// Optional RESULT_READER_AUTO_SCROLL_EN: advance automatically every SCROLL_CYCLES cycles spent in SHOW.
module result_reader
    import result_reader_pkg::*;
#(
    parameter int unsigned ADDR_W    = 7,
    parameter int unsigned DATA_W    = 16,
    parameter int unsigned BASE_ADDR = DEF_BASE_ADDR,
    parameter int unsigned NUM_ELEM  = DEF_NUM_ELEM,
    parameter int unsigned READ_LAT  = 1
`ifdef RESULT_READER_AUTO_SCROLL_EN
    ,
    parameter int unsigned SCROLL_CYCLES = 50_000_000
`endif
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              step,
    output logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_q,
    output logic              busy,
    output logic              valid,
    output logic [4:0]        elem_index,
    output logic [7:0]        elem_value,
    output logic [6:0]        hex0,
    output logic [6:0]        hex1,
    output logic [6:0]        hex2,
    output logic [6:0]        hex_sign
);

    state_e            state_q, state_d;
    logic [1:0]        lat_q;
    logic [ADDR_W-1:0] addr_q;
    logic              busy_q, valid_q, sign_q;
    logic [4:0]        idx_q, idx_d;
    logic [7:0]        value_q;
    logic [6:0]        hex0_q, hex1_q, hex2_q, hex_sign_q;

    logic       step_eff, auto_step, accept, lat_done, dab_start, show_load;
    logic [7:0] magnitude;
    logic       dab_busy_unused, dab_done;
    logic [3:0] dig_h, dig_t, dig_u;

    // Result words are stored zero-extended; only the low byte carries data.
    logic       mem_hi_unused;
    assign mem_hi_unused = ^mem_q[DATA_W-1:8];

`ifdef RESULT_READER_AUTO_SCROLL_EN
    localparam int unsigned SCW = ($clog2(SCROLL_CYCLES) < 1) ? 1 : $clog2(SCROLL_CYCLES);
    logic [SCW-1:0] scroll_q;

    // Held at zero outside SHOW, so every SHOW visit starts a fresh period.
    always_ff @(posedge clk) begin
        if (reset) begin
            scroll_q <= '0;
        end else if (state_q != ST_SHOW || accept) begin
            scroll_q <= '0;
        end else begin
            scroll_q <= scroll_q + 1'b1;
        end
    end

    assign auto_step = (state_q == ST_SHOW) && (scroll_q == SCW'(SCROLL_CYCLES - 1));
`else
    assign auto_step = 1'b0;
`endif

    assign step_eff = step | auto_step;

    // State register.
    always_ff @(posedge clk) begin
        if (reset) state_q <= ST_IDLE;
        else       state_q <= state_d;
    end

    // Next-state logic; start overrides everything and aborts an in-flight fetch.
    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = ST_WAIT;
        end else begin
            case (state_q)
                ST_WAIT:    if (lat_done) state_d = ST_CAPTURE;
                ST_CAPTURE: state_d = ST_CONVERT;
                ST_CONVERT: if (dab_done) state_d = ST_SHOW;
                ST_SHOW:    if (step_eff) state_d = ST_WAIT;
                default:    state_d = state_q;
            endcase
        end
    end

    // Control decode.
    always_comb begin
        accept    = start || (state_q == ST_SHOW && step_eff);
        lat_done  = (lat_q == 2'(READ_LAT - 1));
        // A start in CAPTURE must not launch a conversion of the stale word.
        dab_start = (state_q == ST_CAPTURE) && !start;
        // The dabbler's done is honoured only in CONVERT, so an aborted run can never land.
        show_load = (state_q == ST_CONVERT) && dab_done && !start;
        idx_d     = '0;
        if (!start) begin
            idx_d = (idx_q == 5'(NUM_ELEM - 1)) ? 5'd0 : idx_q + 5'd1;
        end
    end

    assign magnitude = mem_q[7] ? (~mem_q[7:0] + 8'd1) : mem_q[7:0];

    always_ff @(posedge clk) begin
        if (reset) begin
            lat_q      <= '0;
            addr_q     <= ADDR_W'(BASE_ADDR);
            busy_q     <= 1'b0;
            valid_q    <= 1'b0;
            sign_q     <= 1'b0;
            idx_q      <= '0;
            value_q    <= '0;
            hex0_q     <= SEG_BLANK;
            hex1_q     <= SEG_BLANK;
            hex2_q     <= SEG_BLANK;
            hex_sign_q <= SEG_BLANK;
        end else if (accept) begin
            idx_q   <= idx_d;
            addr_q  <= ADDR_W'(BASE_ADDR) + ADDR_W'(idx_d);
            valid_q <= 1'b0;
            busy_q  <= 1'b1;
            lat_q   <= '0;
        end else begin
            if (state_q == ST_WAIT) begin
                lat_q <= lat_q + 2'd1;
            end
            if (state_q == ST_CAPTURE) begin
                value_q <= mem_q[7:0];
                sign_q  <= mem_q[7];
            end
            if (show_load) begin
                hex0_q     <= seg_of(dig_u);
                hex1_q     <= seg_of(dig_t);
                hex2_q     <= seg_of(dig_h);
                hex_sign_q <= sign_q ? SEG_MINUS : SEG_BLANK;
                busy_q     <= 1'b0;
                valid_q    <= 1'b1;
            end
        end
    end

    bcd_dabble8 u_dabble (
        .clk      (clk),
        .reset    (reset),
        .start    (dab_start),
        .bin      (magnitude),
        .busy     (dab_busy_unused),
        .done     (dab_done),
        .hundreds (dig_h),
        .tens     (dig_t),
        .units    (dig_u)
    );

    assign mem_addr   = addr_q;
    assign busy       = busy_q;
    assign valid      = valid_q;
    assign elem_index = idx_q;
    assign elem_value = value_q;
    assign hex0       = hex0_q;
    assign hex1       = hex1_q;
    assign hex2       = hex2_q;
    assign hex_sign   = hex_sign_q;

endmodule
